mem_wb_stage: RTL

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage_if.sv | 35 +++
 rtl/mem_wb_stage.sv | 119 +++++++++++
 2 files changed

// File: rtl/mem_wb_stage_if.sv
// MEM->WB boundary bundle: MEM-side instruction fields in, registered WB-side fields out.
// The master drives the MEM-side fields; the stage uses the slave modport.
interface mem_wb_stage_if #(
   parameter int RD_W = 5,
   parameter int XLEN = 64
);
   logic            mem_valid;
   logic [XLEN-1:0] alu_result;
   logic [XLEN-1:0] mem_rdata;
   logic [2:0]      funct3;
   logic            MemtoReg;
   logic            RegWrite;
   logic [RD_W-1:0] rd;
   logic            stall;
   logic            flush;

   logic [XLEN-1:0] alu_out;
   logic [XLEN-1:0] mem_out;
   logic            MemtoReg_out;
   logic            RegWrite_out;
   logic [RD_W-1:0] rd_out;
   logic            wb_valid;
   logic            misalign_err;
   logic [31:0]     retired;

   modport master (
      output mem_valid, alu_result, mem_rdata, funct3, MemtoReg, RegWrite, rd, stall, flush,
      input  alu_out, mem_out, MemtoReg_out, RegWrite_out, rd_out, wb_valid, misalign_err, retired
   );

   modport slave (
      input  mem_valid, alu_result, mem_rdata, funct3, MemtoReg, RegWrite, rd, stall, flush,
      output alu_out, mem_out, MemtoReg_out, RegWrite_out, rd_out, wb_valid, misalign_err, retired
   );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load extraction/extension; 1-cycle latency.
// No ready output: stall freezes every register, flush inserts a bubble; stall wins.
module mem_wb_stage #(
   parameter int RD_W = 5,
   parameter int XLEN = 64
) (
   input  logic           clk,
   input  logic           reset,
   mem_wb_stage_if.slave  bus
);

   logic [2:0]      offset;
   logic [XLEN-1:0] shifted;
   logic [XLEN-1:0] load_data;
   logic            mis_raw;
   logic            misaligned;

   logic            wb_valid_q,     wb_valid_d;
   logic            reg_write_q,    reg_write_d;
   logic            mem_to_reg_q,   mem_to_reg_d;
   logic [RD_W-1:0] rd_q,           rd_d;
   logic [XLEN-1:0] alu_q,          alu_d;
   logic [XLEN-1:0] mem_q,          mem_d;
   logic            err_q,          err_d;
   logic [31:0]     retired_q,      retired_d;

   // Lane-shift the doubleword so the addressed byte sits at bit 0, then extend.
   always_comb begin
      offset    = bus.alu_result[2:0];
      shifted   = bus.mem_rdata >> {offset, 3'b000};
      load_data = bus.mem_rdata;
      case (bus.funct3)
         3'b000:  load_data = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
         3'b001:  load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
         3'b010:  load_data = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
         3'b100:  load_data = {{(XLEN-8){1'b0}},         shifted[7:0]};
         3'b101:  load_data = {{(XLEN-16){1'b0}},        shifted[15:0]};
         3'b110:  load_data = {{(XLEN-32){1'b0}},        shifted[31:0]};
         default: load_data = bus.mem_rdata;
      endcase
   end

   always_comb begin
      mis_raw = 1'b0;
      case (bus.funct3)
         3'b001, 3'b101: mis_raw = offset[0];
         3'b010, 3'b110: mis_raw = (offset[1:0] != 2'b00);
         3'b011:         mis_raw = (offset != 3'b000);
         3'b111:         mis_raw = 1'b1;
         default:        mis_raw = 1'b0;
      endcase
      misaligned = bus.MemtoReg & mis_raw;
   end

   always_comb begin
      wb_valid_d   = wb_valid_q;
      reg_write_d  = reg_write_q;
      mem_to_reg_d = mem_to_reg_q;
      rd_d         = rd_q;
      alu_d        = alu_q;
      mem_d        = mem_q;
      err_d        = err_q;
      retired_d    = retired_q;
      if (!bus.stall) begin
         if (bus.flush) begin
            // Bubble clears control only; data registers keep their last value.
            wb_valid_d   = 1'b0;
            reg_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
            rd_d         = '0;
         end else begin
            wb_valid_d   = bus.mem_valid;
            reg_write_d  = bus.mem_valid & bus.RegWrite & ~misaligned & (bus.rd != '0);
            mem_to_reg_d = bus.MemtoReg;
            rd_d         = bus.rd;
            alu_d        = bus.alu_result;
            mem_d        = load_data;
            if (bus.mem_valid && misaligned) begin
               err_d = 1'b1;
            end
            if (bus.mem_valid) begin
               retired_d = retired_q + 32'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wb_valid_q   <= 1'b0;
         reg_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         rd_q         <= '0;
         alu_q        <= '0;
         mem_q        <= '0;
         err_q        <= 1'b0;
         retired_q    <= '0;
      end else begin
         wb_valid_q   <= wb_valid_d;
         reg_write_q  <= reg_write_d;
         mem_to_reg_q <= mem_to_reg_d;
         rd_q         <= rd_d;
         alu_q        <= alu_d;
         mem_q        <= mem_d;
         err_q        <= err_d;
         retired_q    <= retired_d;
      end
   end

   assign bus.wb_valid     = wb_valid_q;
   assign bus.RegWrite_out = reg_write_q;
   assign bus.MemtoReg_out = mem_to_reg_q;
   assign bus.rd_out       = rd_q;
   assign bus.alu_out      = alu_q;
   assign bus.mem_out      = mem_q;
   assign bus.misalign_err = err_q;
   assign bus.retired      = retired_q;

endmodule
